fa_share_sched: RTL and testbench
=================================

Name: fa_share_sched

Overview:
- Bit-serial add scheduler that shares one FullAdder cell between two requesters, A and B.
- Each requester presents a pair of WIDTH-bit operands.
- The block arbitrates round-robin, latches the winner's operands and runs one FullAdder bit per clock, LSB first.
- It returns a (WIDTH+1)-bit sum tagged with the owner.
- It sits between the top-level operand sources and the single shared FullAdder instance, replacing the per-sum adder pairs of the combinational top.

Parameters:
- WIDTH, 4, operand width in bits, legal range 1..16.
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not for override).

Ports:
- iClk  in  1  system clock; rising edge.
- iRst_n  in  1  reset, asynchronous assert, active-low.
- iReqA  in  1  requester A wants an add; hold high until oGntA.
- iOpA_A  in  WIDTH  requester A operand X.
- iOpA_B  in  WIDTH  requester A operand Y.
- iReqB  in  1  requester B wants an add; hold high until oGntB.
- iOpB_A  in  WIDTH  requester B operand X.
- iOpB_B  in  WIDTH  requester B operand Y.
- oGntA  out  1  one-cycle pulse: A's operands captured.
- oGntB  out  1  one-cycle pulse: B's operands captured.
- oBusy  out  1  high while in RUN or DONE.
- oDone  out  1  one-cycle pulse: oSum/oOwner valid, new result.
- oSum  out  WIDTH+1  {carry, sum}; holds until next oDone.
- oOwner  out  1  0 = A, 1 = B; holds with oSum.

Behaviour:
- Reset (iRst_n low, async):
  - state = IDLE; all outputs 0.
  - Operand shift registers, carry register and counter cleared.
  - RR pointer = favour A.
- Reset mid-RUN aborts the operation: no oDone, no partial oSum. Requesters must re-request.
- States: IDLE, RUN, DONE.
- IDLE:
  - If no request: stay; oGnt* = 0.
  - If exactly one request: grant it.
  - If both: grant the side the RR pointer favours, then flip the pointer to the other side.
  - A single grant also sets the pointer to favour the other side.
  - On the grant edge:
    - Latch the winner's X/Y into shift registers.
    - Carry reg = 0, counter = 0, owner reg = winner.
    - Pulse the matching oGnt* for the following cycle.
    - Go to RUN.
- RUN:
  - Each edge feeds the FullAdder with iA = X[0], iB = Y[0], iCy = carry reg.
  - The result bit oS shifts into the result register from the MSB side.
  - carry reg <= oCy; X and Y shift right; counter++.
  - When counter reaches WIDTH-1 on an edge (the WIDTH-th processed bit):
    - oSum <= {oCy, result bits}; oOwner <= owner reg; oDone <= 1.
    - Go to DONE.
- DONE: oDone drops after one cycle; go to IDLE. No grant is issued from DONE.
- Latency:
  - oDone rises exactly WIDTH cycles after oGnt* rises.
  - Minimum grant-to-grant spacing is WIDTH+2 cycles.
- Requests in RUN/DONE are ignored and not queued. A request still held on return to IDLE is arbitrated normally.
- A request dropped before its grant is withdrawn without side effects.
- Operand inputs are sampled only on the grant edge; later changes have no effect.
- Arithmetic: unsigned, no overflow loss; carry-out lands in oSum[WIDTH].
- oBusy = (state != IDLE).
- oGntA and oGntB are never high together.
- oDone and oGnt* are never high in the same cycle.

Decomposition:
- Shared package fa_sched_pkg:
  - State enum (IDLE, RUN, DONE).
  - Owner encodings (OWN_A = 0, OWN_B = 1).
- Sub-module: the existing FullAdder, ports iA, iB, iCy, oS, oCy. It is instantiated exactly once and is the only adder logic in the block.
- Arbiter and state machine are inline; no further sub-modules.

Test Plan:
- WIDTH=4, reset then iReqA=1, A operands 5 and 6:
  - oGntA pulses once.
  - 4 cycles later oDone = 1 with oSum = 5'b01011 (11) and oOwner = 0.
  - oBusy is high from the grant cycle through the oDone cycle.
- iReqB only, B operands 15 and 15: oSum = 5'b11110 (30), oOwner = 1, carry bit set.
- iReqA and iReqB held together for 3 transactions (A: 1+2, B: 7+8, A: 1+2):
  - Grants go A, B, A.
  - Sums are 3, 15, 3.
  - Grant spacing is exactly 6 cycles.
- iRst_n low 2 cycles into RUN:
  - All outputs go to 0 immediately.
  - No oDone follows.
  - After release, iReqB alone wins first because the pointer is reset to favour A but A is idle.
- During RUN, change iOpA_A/B and toggle iReqB:
  - The result is unchanged.
  - B is granted only if still held at the return to IDLE.
- WIDTH=1 build:
  - 1+1 -> oSum = 2'b10, oDone 1 cycle after oGnt.
  - 0+0 -> oSum = 0.

Source files
------------

// File: rtl/fa_sched_pkg.sv
// Shared types for the shared-FullAdder bit-serial add scheduler.
package fa_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/fa_share_sched_fa.sv
// Single-bit full adder cell; the one adder shared by both requesters.
module FullAdder (
  input  logic iA,
  input  logic iB,
  input  logic iCy,
  output logic oS,
  output logic oCy
);

  assign oS  = iA ^ iB ^ iCy;
  assign oCy = (iA & iB) | (iCy & (iA ^ iB));

endmodule

// File: rtl/fa_share_sched.sv
// Round-robin scheduler that runs two requesters' adds bit-serially
// through one shared FullAdder, LSB first, one bit per clock.
module fa_share_sched
  import fa_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iReqA,
  input  logic [WIDTH-1:0] iOpA_A,
  input  logic [WIDTH-1:0] iOpA_B,
  input  logic             iReqB,
  input  logic [WIDTH-1:0] iOpB_A,
  input  logic [WIDTH-1:0] iOpB_B,
  output logic             oGntA,
  output logic             oGntB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH:0]   oSum,
  output logic             oOwner
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             cy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             own_q;
  logic             rr_q;
  logic             gnt_a_q;
  logic             gnt_b_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   sum_q;
  logic             owner_q;

  logic fa_s;
  logic fa_cy;
  logic any_req_c;
  logic win_b_c;
  logic last_c;

  FullAdder u_fa (
    .iA  (x_q[0]),
    .iB  (y_q[0]),
    .iCy (cy_q),
    .oS  (fa_s),
    .oCy (fa_cy)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_d = WIDTH'({fa_s, res_q} >> 1);

  // rr_q high means B is favoured when both requesters are asking.
  assign any_req_c = iReqA | iReqB;
  assign win_b_c   = iReqB & (~iReqA | rr_q);
  assign last_c    = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      own_q   <= OWN_A;
      rr_q    <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      owner_q <= OWN_A;
    end else begin
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_c) begin
            x_q     <= win_b_c ? iOpB_A : iOpA_A;
            y_q     <= win_b_c ? iOpB_B : iOpA_B;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            own_q   <= win_b_c ? OWN_B : OWN_A;
            rr_q    <= ~win_b_c;
            gnt_a_q <= ~win_b_c;
            gnt_b_q <= win_b_c;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q   <= x_q >> 1;
          y_q   <= y_q >> 1;
          cy_q  <= fa_cy;
          res_q <= res_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_c) begin
            sum_q   <= {fa_cy, res_d};
            owner_q <= own_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oGntA  = gnt_a_q;
  assign oGntB  = gnt_b_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;
  assign oSum   = sum_q;
  assign oOwner = owner_q;

endmodule

// File: tb/tb_fa_share_sched.sv
// Directed bench for fa_share_sched: WIDTH=4 and WIDTH=1 instances with a result scoreboard.
module tb_fa_share_sched;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic         own;
    logic [W:0]   sum;
  } exp_t;

  logic clk;
  logic rst_n;

  logic         req_a, req_b;
  logic [W-1:0] op_a_x, op_a_y, op_b_x, op_b_y;
  logic         gnt_a, gnt_b, busy, done, owner;
  logic [W:0]   sum;

  logic       r1_a, r1_b;
  logic [0:0] a1_x, a1_y, b1_x, b1_y;
  logic       g1_a, g1_b, busy1, done1, owner1;
  logic [1:0] sum1;

  exp_t       sb[$];
  logic [2:0] sb1[$];
  int vectors;
  int miscompares;

  fa_share_sched #(.WIDTH(W)) dut4 (
    .iClk(clk), .iRst_n(rst_n),
    .iReqA(req_a), .iOpA_A(op_a_x), .iOpA_B(op_a_y),
    .iReqB(req_b), .iOpB_A(op_b_x), .iOpB_B(op_b_y),
    .oGntA(gnt_a), .oGntB(gnt_b), .oBusy(busy), .oDone(done),
    .oSum(sum), .oOwner(owner)
  );

  fa_share_sched #(.WIDTH(1)) dut1 (
    .iClk(clk), .iRst_n(rst_n),
    .iReqA(r1_a), .iOpA_A(a1_x), .iOpA_B(a1_y),
    .iReqB(r1_b), .iOpB_A(b1_x), .iOpB_B(b1_y),
    .oGntA(g1_a), .oGntB(g1_b), .oBusy(busy1), .oDone(done1),
    .oSum(sum1), .oOwner(owner1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int cyc, output logic who);
    logic got;
    got = 1'b0;
    who = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (gnt_a || gnt_b) begin
        got = 1'b1;
        who = gnt_b;
        chk("gnt_exclusive", {30'd0, gnt_a & gnt_b, gnt_b & done}, 32'd0);
        break;
      end
    end
    chk("gnt_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    logic got;
    exp_t e;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_timeout", {31'd0, got}, 32'd1);
    if (got) begin
      chk("busy_at_done", {31'd0, busy}, 32'd1);
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sum", {27'd0, sum}, {27'd0, e.sum});
        chk("owner", {31'd0, owner}, {31'd0, e.own});
      end
    end
  endtask

  task automatic w1_txn(input logic side_b, input logic x, input logic y);
    logic got;
    logic [2:0] e;
    got = 1'b0;
    if (side_b) begin r1_b = 1'b1; b1_x = x; b1_y = y; end
    else begin r1_a = 1'b1; a1_x = x; a1_y = y; end
    sb1.push_back({side_b, 2'({1'b0, x} + {1'b0, y})});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (g1_a || g1_b) begin got = 1'b1; break; end
    end
    chk("w1_gnt", {30'd0, g1_b, got}, {30'd0, side_b, 1'b1});
    r1_a = 1'b0;
    r1_b = 1'b0;
    @(negedge clk);
    chk("w1_done_latency", {31'd0, done1}, 32'd1);
    e = sb1.pop_front();
    chk("w1_sum_owner", {29'd0, owner1, sum1}, {29'd0, e});
  endtask

  initial begin
    int c, dc, ndone;
    logic who;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    op_a_x = '0; op_a_y = '0; op_b_x = '0; op_b_y = '0;
    r1_a = 1'b0; r1_b = 1'b0;
    a1_x = '0; a1_y = '0; b1_x = '0; b1_y = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {25'd0, gnt_a, gnt_b, busy, done, owner, |sum, 1'b0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // A alone: 5 + 6
    req_a = 1'b1; op_a_x = 4'd5; op_a_y = 4'd6;
    sb.push_back('{own: 1'b0, sum: 5'd11});
    wait_gnt(c, who);
    chk("t1_gnt_side", {31'd0, who}, 32'd0);
    chk("t1_gnt_lat", c, 32'd1);
    chk("t1_busy_at_gnt", {31'd0, busy}, 32'd1);
    req_a = 1'b0;
    wait_done(dc);
    chk("t1_done_lat", dc, W);
    @(negedge clk);
    chk("t1_after_done", {29'd0, done, busy, gnt_a}, 32'd0);
    chk("t1_sum_hold", {27'd0, sum}, 32'd11);

    // B alone: 15 + 15, carry-out set
    req_b = 1'b1; op_b_x = 4'd15; op_b_y = 4'd15;
    sb.push_back('{own: 1'b1, sum: 5'd30});
    wait_gnt(c, who);
    chk("t2_gnt_side", {31'd0, who}, 32'd1);
    req_b = 1'b0;
    wait_done(dc);
    chk("t2_carry", {31'd0, sum[W]}, 32'd1);
    @(negedge clk);

    // Both held: A, B, A with back-to-back spacing
    req_a = 1'b1; op_a_x = 4'd1; op_a_y = 4'd2;
    req_b = 1'b1; op_b_x = 4'd7; op_b_y = 4'd8;
    sb.push_back('{own: 1'b0, sum: 5'd3});
    sb.push_back('{own: 1'b1, sum: 5'd15});
    sb.push_back('{own: 1'b0, sum: 5'd3});
    dc = 0;
    for (int t = 0; t < 3; t++) begin
      wait_gnt(c, who);
      chk("t3_rr_side", {31'd0, who}, {31'd0, t == 1});
      if (t > 0) chk("t3_spacing", c + dc, W + 2);
      if (t == 2) begin req_a = 1'b0; req_b = 1'b0; end
      wait_done(dc);
    end
    @(negedge clk);

    // Reset two cycles into RUN aborts the add
    req_a = 1'b1; op_a_x = 4'd3; op_a_y = 4'd3;
    wait_gnt(c, who);
    req_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_async_clear", {26'd0, gnt_a, gnt_b, busy, done, owner, |sum}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t4_no_done", ndone, 32'd0);
    req_b = 1'b1; op_b_x = 4'd9; op_b_y = 4'd4;
    sb.push_back('{own: 1'b1, sum: 5'd13});
    wait_gnt(c, who);
    chk("t4_b_first", {31'd0, who}, 32'd1);
    req_b = 1'b0;
    wait_done(dc);
    @(negedge clk);

    // Operand changes and B request toggling during RUN
    req_a = 1'b1; op_a_x = 4'd6; op_a_y = 4'd7;
    sb.push_back('{own: 1'b0, sum: 5'd13});
    wait_gnt(c, who);
    req_a = 1'b0; op_a_x = 4'd15; op_a_y = 4'd15;
    req_b = 1'b1; op_b_x = 4'd1; op_b_y = 4'd1;
    @(negedge clk);
    req_b = 1'b0;
    @(negedge clk);
    req_b = 1'b1; op_b_x = 4'd2; op_b_y = 4'd3;
    sb.push_back('{own: 1'b1, sum: 5'd5});
    wait_done(dc);
    wait_gnt(c, who);
    chk("t5_b_after_idle", {31'd0, who}, 32'd1);
    chk("t5_b_gnt_gap", c, 32'd2);
    req_b = 1'b0;
    wait_done(dc);
    chk("t5_done_lat", dc, W);
    chk("sb_drained", sb.size(), 32'd0);

    // WIDTH=1 instance
    w1_txn(1'b0, 1'b1, 1'b1);
    w1_txn(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
